// File: rtl/rr_pkg.sv
// rr_pkg: shared state encoding and width helpers for the round-robin dispatcher
package rr_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int credit_width(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/rr_credit_counter.sv
// rr_credit_counter: per-port credit counter saturating at MAX_CREDITS
//   clk, reset  : clock, synchronous active-high reset (counter reloads to MAX_CREDITS)
//   inc_i       : credit returned this cycle
//   dec_i       : credit consumed by a dispatch this cycle
//   nonzero_o   : at least one credit available
//   ovf_o       : return arrived while full with no same-edge consume (ignored)
module rr_credit_counter import rr_pkg::*; #(
  parameter int MAX_CREDITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic ovf_o
);
  localparam int CW = credit_width(MAX_CREDITS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic at_max;
  always_comb begin
    at_max = cnt_q == CW'(MAX_CREDITS);
    ovf_o = inc_i && !dec_i && at_max;
    nonzero_o = |cnt_q;
    cnt_d = (inc_i && !dec_i && !at_max) ? cnt_q + 1'b1 :
            (dec_i && !inc_i)            ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (reset) cnt_q <= CW'(MAX_CREDITS);
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rr_dispatcher.sv
// rr_dispatcher: one-entry buffer dispatching words round-robin to credited ports
//   clk, reset     : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : upstream valid/ready handshake
//   out_valid      : registered one-hot port strobe; out_data : registered shared payload
//   credit_return  : per-port credit return pulses
//   pointer        : round-robin search start; credit_err : sticky over-return flag
module rr_dispatcher import rr_pkg::*; #(
  parameter int NUMBER_PORTS = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_CREDITS  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 in_ready,
  output logic [NUMBER_PORTS-1:0]              out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  input  logic [NUMBER_PORTS-1:0]              credit_return,
  output logic [ptr_width(NUMBER_PORTS)-1:0]   pointer,
  output logic                                 credit_err
);
  localparam int PW = ptr_width(NUMBER_PORTS);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, data_q, data_d;
  logic [NUMBER_PORTS-1:0] valid_q, valid_d, nz, ovf;
  logic [PW-1:0] ptr_q, ptr_d, sel;
  logic dispatch, xfer, err_q, err_d;
  // Walk backwards so the port closest to the pointer is the last (winning) assignment.
  always_comb begin
    sel = '0;
    for (int k = NUMBER_PORTS - 1; k >= 0; k--)
      if (nz[(int'(ptr_q) + k) % NUMBER_PORTS]) sel = PW'((int'(ptr_q) + k) % NUMBER_PORTS);
  end
  always_comb begin
    dispatch = (state_q == FULL) && |nz;
    in_ready = (state_q == EMPTY) || dispatch;
    xfer = in_valid && in_ready;
    state_d = xfer ? FULL : dispatch ? EMPTY : state_q;
    hold_d = xfer ? in_data : hold_q;
    valid_d = dispatch ? NUMBER_PORTS'(1) << sel : '0;
    data_d = dispatch ? hold_q : data_q;
    ptr_d = !dispatch ? ptr_q : (sel == PW'(NUMBER_PORTS - 1)) ? '0 : sel + 1'b1;
    err_d = err_q | |ovf;
  end
  for (genvar i = 0; i < NUMBER_PORTS; i++) begin : g_cnt
    rr_credit_counter #(.MAX_CREDITS(MAX_CREDITS)) u_cnt (
      .clk(clk), .reset(reset), .inc_i(credit_return[i]), .dec_i(valid_d[i]),
      .nonzero_o(nz[i]), .ovf_o(ovf[i]));
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= EMPTY;
      hold_q <= '0;
      valid_q <= '0;
      data_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      valid_q <= valid_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign pointer = ptr_q;
  assign credit_err = err_q;
endmodule

// File: tb/tb_rr_dispatcher.sv
// tb_rr_dispatcher: directed and random checks of two dispatcher configurations against a reference model
module tb_rr_dispatcher;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid;
  logic [31:0] in_data;
  logic [1:0] cr2;
  logic [3:0] cr4;
  logic rdy2, rdy4, err2, err4;
  logic [1:0] ov2, ptr4;
  logic [3:0] ov4;
  logic [31:0] od2, od4;
  logic [0:0] ptr2;
  rr_dispatcher #(.NUMBER_PORTS(2), .DATA_WIDTH(32), .MAX_CREDITS(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .credit_return(cr2), .pointer(ptr2), .credit_err(err2));
  rr_dispatcher #(.NUMBER_PORTS(4), .DATA_WIDTH(32), .MAX_CREDITS(2)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .credit_return(cr4), .pointer(ptr4), .credit_err(err4));
  int nports[2] = '{2, 4};
  int maxc[2] = '{4, 2};
  bit m_full[2], m_err[2];
  logic [31:0] m_held[2], m_od[2];
  int m_ov[2], m_ptr[2];
  int m_cred[2][4];
  int compared = 0, mismatched = 0;
  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
    end
  endtask
  function automatic bit m_rdy(input int d);
    bit any = 0;
    for (int p = 0; p < nports[d]; p++) if (m_cred[d][p] > 0) any = 1;
    return !m_full[d] || any;
  endfunction
  task automatic model(input int d, input bit rst, input bit iv, input logic [31:0] data, input logic [3:0] cr);
    int n, mx, sel;
    bit disp, xfer, dec;
    n = nports[d];
    mx = maxc[d];
    if (rst) begin
      m_full[d] = 0; m_held[d] = 0; m_ov[d] = 0; m_od[d] = 0; m_ptr[d] = 0; m_err[d] = 0;
      for (int p = 0; p < 4; p++) m_cred[d][p] = mx;
      return;
    end
    sel = -1;
    for (int k = 0; k < n; k++)
      if (sel < 0 && m_cred[d][(m_ptr[d] + k) % n] > 0) sel = (m_ptr[d] + k) % n;
    disp = m_full[d] && sel >= 0;
    xfer = iv && (!m_full[d] || disp);
    m_ov[d] = disp ? (1 << sel) : 0;
    if (disp) begin
      m_od[d] = m_held[d];
      m_ptr[d] = (sel + 1) % n;
    end
    for (int p = 0; p < n; p++) begin
      dec = disp && p == sel;
      if (cr[p] && !dec) begin
        if (m_cred[d][p] == mx) m_err[d] = 1;
        else m_cred[d][p]++;
      end else if (dec && !cr[p]) m_cred[d][p]--;
    end
    if (xfer) begin
      m_full[d] = 1;
      m_held[d] = data;
    end else if (disp) m_full[d] = 0;
  endtask
  task automatic step(input bit rst, input bit iv, input logic [31:0] data, input logic [1:0] r2, input logic [3:0] r4);
    reset = rst; in_valid = iv; in_data = data; cr2 = r2; cr4 = r4;
    model(0, rst, iv, data, {2'b00, r2});
    model(1, rst, iv, data, r4);
    @(posedge clk);
    #1;
    check("out_valid", 0, 32'(ov2), 32'(m_ov[0]));
    check("out_data", 0, od2, m_od[0]);
    check("pointer", 0, 32'(ptr2), 32'(m_ptr[0]));
    check("credit_err", 0, 32'(err2), 32'(m_err[0]));
    check("in_ready", 0, 32'(rdy2), 32'(m_rdy(0)));
    check("out_valid", 1, 32'(ov4), 32'(m_ov[1]));
    check("out_data", 1, od4, m_od[1]);
    check("pointer", 1, 32'(ptr4), 32'(m_ptr[1]));
    check("credit_err", 1, 32'(err4), 32'(m_err[1]));
    check("in_ready", 1, 32'(rdy4), 32'(m_rdy(1)));
  endtask
  initial begin
    logic [31:0] seq[3] = '{32'hA, 32'hB, 32'hC};
    logic [1:0] exp_ov[3] = '{2'b01, 2'b10, 2'b01};
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_ready", 0, 32'(rdy2), 32'd1);
    step(0, 1, seq[0], 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, i < 2, (i < 2) ? seq[i + 1] : 32'h0, 0, 0);
      check("seq_ov", 0, 32'(ov2), 32'(exp_ov[i]));
      check("seq_data", 0, od2, seq[i]);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 32'h100 + 32'(i), 0, 0);
    step(0, 1, 32'hDEAD, 0, 0);
    check("stall_ready", 0, 32'(rdy2), 32'd0);
    step(0, 0, 0, 2'b01, 4'b0100);
    check("ret_no_out", 0, 32'(ov2), 32'd0);
    step(0, 1, 32'h200, 0, 0);
    check("ret_dispatch", 0, 32'(ov2), 32'd1);
    check("ret_word", 0, od2, 32'h108);
    check("p2_dispatch", 1, 32'(ov4), 32'b0100);
    check("p2_pointer", 1, 32'(ptr4), 32'd3);
    step(0, 0, 0, 0, 4'b0010);
    step(0, 0, 0, 0, 0);
    check("wrap_port1", 1, 32'(ov4), 32'b0010);
    check("wrap_pointer", 1, 32'(ptr4), 32'd2);
    step(0, 1, 32'h300, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("post_reset_ov", 0, 32'(ov2), 32'd0);
    check("post_reset_ready", 0, 32'(rdy2), 32'd1);
    step(0, 0, 0, 2'b01, 0);
    check("over_return", 0, 32'(err2), 32'd1);
    step(0, 0, 0, 0, 0);
    check("err_sticky", 0, 32'(err2), 32'd1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom,
           2'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom_range(0, 2) == 0 ? $urandom & $urandom : 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
